// File: rtl/hazard_control_unit.sv
// Hazard control for the execute/writeback pipeline: operand forwarding select,
// load-use and memory-wait stalls, redirect flushes and stall/flush counters.

module hcu_fwd_sel (
    input  logic [4:0] src_i,
    input  logic [4:0] a3_w_i,
    input  logic       we_e_w_i,
    input  logic [4:0] a4_w2_i,
    input  logic       we_w_w2_i,
    input  logic       ex_path_i,
    output logic [1:0] fwd_o
);
    logic hit_w;
    logic hit_w2;

    assign hit_w  = we_e_w_i  && (src_i == a3_w_i)  && (src_i != 5'd0);
    assign hit_w2 = we_w_w2_i && (src_i == a4_w2_i) && (src_i != 5'd0);

    // Younger Writeback result shadows the older W2 result for the same register.
    always_comb begin
        fwd_o = 2'd0;
        if (hit_w)
            fwd_o = 2'd1;
        else if (hit_w2)
            fwd_o = ex_path_i ? 2'd3 : 2'd2;
    end
endmodule

module hazard_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1_E,
    input  logic [4:0]  A2_E,
    input  logic [4:0]  A3_W,
    input  logic        RegWE_E_W,
    input  logic [4:0]  A4_W,
    input  logic        RegWE_W_W,
    input  logic [4:0]  A4_W2,
    input  logic        RegWE_W_W2,
    input  logic [1:0]  ExPathW2,
    input  logic [1:0]  PCSrcE,
    input  logic        mem_req_W,
    input  logic        mem_ready,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallW,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  fwdA_E,
    output logic [1:0]  fwdB_E,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);
    localparam int NUM_OPS = 2;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [NUM_OPS-1:0][4:0] src;
    logic [NUM_OPS-1:0][1:0] fwd_raw;
    logic                    mem_wait;
    logic                    load_use;
    logic                    any_stall;
    logic [31:0]             stall_cnt_q, stall_cnt_d;
    logic [31:0]             flush_cnt_q, flush_cnt_d;
    logic                    unused_expath;

    assign src           = {A2_E, A1_E};
    assign unused_expath = ExPathW2[1];

    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_fwd
        hcu_fwd_sel u_fwd (
            .src_i     (src[gi]),
            .a3_w_i    (A3_W),
            .we_e_w_i  (RegWE_E_W),
            .a4_w2_i   (A4_W2),
            .we_w_w2_i (RegWE_W_W2),
            .ex_path_i (ExPathW2[0]),
            .fwd_o     (fwd_raw[gi])
        );
    end

    assign mem_wait = mem_req_W && !mem_ready;
    assign load_use = RegWE_W_W && (A4_W != 5'd0) &&
                      ((A1_E == A4_W) || (A2_E == A4_W));

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (mem_wait)
                    state_d = MEM_WAIT;
                else if (load_use)
                    state_d = LOAD_STALL;
            end
            LOAD_STALL: state_d = mem_wait ? MEM_WAIT : RUN;
            MEM_WAIT:   state_d = mem_wait ? MEM_WAIT : RUN;
            default:    state_d = RUN;
        endcase
    end

    // Controls follow the live inputs so a hazard is covered in the cycle it appears;
    // a redirect seen while stalled is dropped and re-presented once released.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallW = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        fwdA_E = fwd_raw[0];
        fwdB_E = fwd_raw[1];
        if (reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
            fwdA_E = 2'd0;
            fwdB_E = 2'd0;
        end else if (mem_wait) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallW = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE != 2'd0) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end
    end

    assign any_stall   = StallF || StallD || StallE || StallW;
    assign stall_cnt_d = stall_cnt_q + 32'(any_stall);
    assign flush_cnt_d = flush_cnt_q + 32'(FlushD);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: constant vector table, hand sequences for
// multi-cycle cases, and randomized traffic against a rule-level model.

module tb_hazard_control_unit;
    typedef struct packed {
        logic       rst;
        logic [4:0] a1, a2, a3, a4, a4w2;
        logic       we_e, we_w, we_w2;
        logic [1:0] ex, pc;
        logic       mreq, mrdy;
    } in_t;

    typedef struct packed {
        logic       sf, sd, se, sw, fd, fe, fw;
        logic [1:0] fa, fb;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1_E, A2_E, A3_W, A4_W, A4_W2;
    logic        RegWE_E_W, RegWE_W_W, RegWE_W_W2;
    logic [1:0]  ExPathW2, PCSrcE;
    logic        mem_req_W, mem_ready;
    logic        StallF, StallD, StallE, StallW, FlushD, FlushE, FlushW;
    logic [1:0]  fwdA_E, fwdB_E;
    logic [31:0] stall_cnt, flush_cnt;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_scnt = 0, exp_fcnt = 0;
    bit          chk_cnt  = 0;
    vec_t        tbl [12];

    always #5 clk = ~clk;

    hazard_control_unit dut (
        .clk(clk), .reset(reset),
        .A1_E(A1_E), .A2_E(A2_E), .A3_W(A3_W), .RegWE_E_W(RegWE_E_W),
        .A4_W(A4_W), .RegWE_W_W(RegWE_W_W),
        .A4_W2(A4_W2), .RegWE_W_W2(RegWE_W_W2), .ExPathW2(ExPathW2),
        .PCSrcE(PCSrcE), .mem_req_W(mem_req_W), .mem_ready(mem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    function automatic logic [1:0] fwd_of(input in_t v, input logic [4:0] s);
        if (s == 0) return 2'd0;
        if (v.we_e && s == v.a3) return 2'd1;
        if (v.we_w2 && s == v.a4w2) return v.ex[0] ? 2'd3 : 2'd2;
        return 2'd0;
    endfunction

    function automatic out_t model(input in_t v);
        out_t o;
        bit   mw, lu;
        o  = '0;
        mw = v.mreq && !v.mrdy;
        lu = v.we_w && v.a4 != 0 && (v.a1 == v.a4 || v.a2 == v.a4);
        if (v.rst) begin
            {o.fd, o.fe, o.fw} = 3'b111;
            return o;
        end
        o.fa = fwd_of(v, v.a1);
        o.fb = fwd_of(v, v.a2);
        if (mw)               {o.sf, o.sd, o.se, o.sw} = 4'b1111;
        else if (lu)          {o.sf, o.sd, o.se, o.fw} = 4'b1111;
        else if (v.pc != 0)   {o.fd, o.fe} = 2'b11;
        return o;
    endfunction

    function automatic out_t sample();
        return '{sf:StallF, sd:StallD, se:StallE, sw:StallW, fd:FlushD,
                 fe:FlushE, fw:FlushW, fa:fwdA_E, fb:fwdB_E};
    endfunction

    task automatic check_out(input string nm, input out_t act, input out_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%b expected=%b", nm, act, exp);
        end
    endtask

    task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Counters reflect the previous cycle's decision, so check before driving.
    task automatic step(input in_t v);
        out_t m;
        @(negedge clk);
        if (chk_cnt) begin
            check_val("stall_cnt", stall_cnt, exp_scnt);
            check_val("flush_cnt", flush_cnt, exp_fcnt);
        end
        reset = v.rst;     A1_E = v.a1;       A2_E = v.a2;
        A3_W = v.a3;       A4_W = v.a4;       A4_W2 = v.a4w2;
        RegWE_E_W = v.we_e; RegWE_W_W = v.we_w; RegWE_W_W2 = v.we_w2;
        ExPathW2 = v.ex;   PCSrcE = v.pc;     mem_req_W = v.mreq;
        mem_ready = v.mrdy;
        #1;
        m = model(v);
        if (v.rst) begin
            exp_scnt = 0;
            exp_fcnt = 0;
        end else begin
            exp_scnt = exp_scnt + 32'(m.sf | m.sd | m.se | m.sw);
            exp_fcnt = exp_fcnt + 32'(m.fd);
        end
    endtask

    in_t idle, rst_v, v;

    initial begin
        idle  = '{mrdy:1'b1, default:'0};
        rst_v = '{rst:1'b1, mrdy:1'b1, default:'0};

        tbl[0]  = '{i:'{a1:5, a3:5, we_e:1, mrdy:1, default:0}, o:'{fa:1, default:0}};
        tbl[1]  = '{i:'{a1:0, a3:0, we_e:1, mrdy:1, default:0}, o:'{default:0}};
        tbl[2]  = '{i:'{a2:7, a4:7, we_w:1, mrdy:1, default:0},
                    o:'{sf:1, sd:1, se:1, fw:1, default:0}};
        tbl[3]  = '{i:'{a2:7, a4w2:7, we_w2:1, ex:1, mrdy:1, default:0}, o:'{fb:3, default:0}};
        tbl[4]  = '{i:'{a2:7, a4w2:7, we_w2:1, ex:2, mrdy:1, default:0}, o:'{fb:2, default:0}};
        tbl[5]  = '{i:'{a1:3, a3:3, we_e:1, a4w2:3, we_w2:1, mrdy:1, default:0},
                    o:'{fa:1, default:0}};
        tbl[6]  = '{i:'{pc:1, mrdy:1, default:0}, o:'{fd:1, fe:1, default:0}};
        tbl[7]  = '{i:'{a1:9, a4:9, we_w:1, pc:1, mrdy:1, default:0},
                    o:'{sf:1, sd:1, se:1, fw:1, default:0}};
        tbl[8]  = '{i:'{a1:9, a4:9, we_w:1, pc:2, mreq:1, mrdy:0, a2:4, a3:4, we_e:1, default:0},
                    o:'{sf:1, sd:1, se:1, sw:1, fb:1, default:0}};
        tbl[9]  = '{i:'{rst:1, a1:5, a3:5, we_e:1, pc:1, mreq:1, default:0},
                    o:'{fd:1, fe:1, fw:1, default:0}};
        tbl[10] = '{i:'{a1:4, a3:4, we_e:0, a4w2:4, we_w2:1, ex:3, mrdy:1, default:0},
                    o:'{fa:3, default:0}};
        tbl[11] = '{i:'{a1:0, a2:0, a4:0, we_w:1, mrdy:1, default:0}, o:'{default:0}};

        step(rst_v);
        step(rst_v);
        check_out("reset_outputs", sample(), '{fd:1, fe:1, fw:1, default:0});
        chk_cnt = 1;

        foreach (tbl[k]) begin
            step(tbl[k].i);
            check_out($sformatf("vec%0d", k), sample(), tbl[k].o);
        end

        // Load-use then W2 forward: exactly one stall cycle counted.
        step(rst_v);
        step(tbl[2].i);
        step(tbl[3].i);
        check_out("lu_release", sample(), '{fb:3, default:0});
        step(idle);
        check_val("lu_stall_cnt", stall_cnt, 32'd1);

        // Redirect alone counts one flush.
        step(rst_v);
        step(tbl[6].i);
        step(idle);
        check_val("redirect_flush_cnt", flush_cnt, 32'd1);
        check_out("redirect_over", sample(), '{default:0});

        // Three memory-wait cycles, then ready.
        step(rst_v);
        v = '{mreq:1, mrdy:0, default:0};
        for (int c = 0; c < 3; c++) begin
            step(v);
            check_out("mem_wait_stall", sample(), '{sf:1, sd:1, se:1, sw:1, default:0});
        end
        v.mrdy = 1;
        step(v);
        check_out("mem_ready_release", sample(), '{default:0});
        check_val("mem_wait_stall_cnt", stall_cnt, 32'd3);

        // Reset in the middle of a memory wait abandons it.
        v.mrdy = 0;
        step(v);
        v.rst = 1;
        step(v);
        check_out("reset_mid_wait", sample(), '{fd:1, fe:1, fw:1, default:0});
        step(idle);
        check_val("reset_mid_wait_cnt", stall_cnt, 32'd0);
        check_out("run_after_reset", sample(), '{default:0});

        // Counter wrap.
        @(negedge clk);
        dut.stall_cnt_q = 32'hFFFF_FFFF;
        exp_scnt = 32'hFFFF_FFFF;
        step('{mreq:1, mrdy:0, default:0});
        step(idle);
        check_val("stall_cnt_wrap", stall_cnt, 32'd0);

        // Random traffic on a small register range to provoke hits.
        for (int n = 0; n < 400; n++) begin
            v.rst   = ($urandom_range(0, 24) == 0);
            v.a1    = 5'($urandom_range(0, 7));
            v.a2    = 5'($urandom_range(0, 7));
            v.a3    = 5'($urandom_range(0, 7));
            v.a4    = 5'($urandom_range(0, 7));
            v.a4w2  = 5'($urandom_range(0, 7));
            v.we_e  = 1'($urandom);
            v.we_w  = ($urandom_range(0, 3) == 0);
            v.we_w2 = 1'($urandom);
            v.ex    = 2'($urandom);
            v.pc    = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            v.mreq  = 1'($urandom);
            v.mrdy  = ($urandom_range(0, 3) != 0);
            step(v);
            check_out("random", sample(), model(v));
        end
        step(idle);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
